alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Parametrised execute stage that merges ALU control decode with the datapath. It decodes `alu_op`/`funct3`/`funct7` into a full RV32I integer operation set and, optionally, the RV32M multiply/divide set. Single-cycle operations return a registered result one cycle after acceptance. Multiply/divide runs on an iterative radix-2 engine. Valid/ready handshakes on both sides let it sit between the decode and writeback pipeline registers.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; power of two, ≥ 8. Shift amount width `SHW = $clog2(XLEN)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: request valid.
- `in_ready` out 1: unit can accept a request this cycle.
- `alu_op` in 2: 00 ADD, 01 SUB (branch compare), 10 decode `funct3`/`funct7`, 11 pass B (LUI).
- `funct3` in 3: operation select when `alu_op`=10.
- `funct7b5` in 1: SUB/SRA select.
- `funct7b0` in 1: M-extension select (R-type only).
- `is_rtype` in 1: 1 = register-register instruction, 0 = immediate.
- `a`, `b` in XLEN: operands.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out XLEN: registered result.
- `zero` out 1: registered (`result` == 0).
- `busy` out 1: iterative engine active (state CALC).

## Operation
- Request handshake: a request is accepted when `in_valid && in_ready`.
- Result handshake: a result is retired when `out_valid && out_ready`.
- `in_ready` = (state==IDLE) || (state==DONE && `out_ready`). This gives back-to-back single-cycle throughput of 1 per cycle.
- `alu_op`=10 decode by `funct3`:
  - 000 ADD, or SUB when `is_rtype && funct7b5`.
  - 001 SLL.
  - 010 SLT (signed).
  - 011 SLTU.
  - 100 XOR.
  - 101 SRL, or SRA when `funct7b5` (SRAI included, `is_rtype` ignored).
  - 110 OR.
  - 111 AND.
- Shifts use `b[SHW-1:0]` only.
- SLT/SLTU return 1 or 0, zero-extended.
- ADD/SUB wrap modulo 2^XLEN.
- M ops apply when `alu_op`=10, `is_rtype`, and `funct7b0`. `funct3` selects:
  - 000 MUL (low XLEN bits).
  - 001 MULH (s×s).
  - 010 MULHSU (s×u).
  - 011 MULHU (u×u).
  - 100 DIV.
  - 101 DIVU.
  - 110 REM.
  - 111 REMU.
- Multiply: shift-add on operand magnitudes with a 2·XLEN accumulator, one bit per cycle, then sign fix-up. The low or high half is selected per op.
- Divide: restoring division on magnitudes, one quotient bit per cycle. Quotient sign = sign(a)^sign(b); remainder takes the sign of the dividend.
- Special cases are resolved at acceptance, with no CALC phase:
  - Divide by zero: quotient = all ones; remainder = `a`.
  - Signed overflow (a = −2^(XLEN−1), b = −1): quotient = `a`; remainder = 0.
- FSM states IDLE, CALC, DONE:
  - IDLE → DONE on accept of a single-cycle op or special case. `result` and `zero` are loaded.
  - IDLE → CALC on accept of a multi-cycle M op. Operands are latched and the iteration counter is set to XLEN.
  - CALC: one iteration per cycle. When the counter reaches 0, do the fix-up and go → DONE.
  - DONE: `out_valid`=1. On `out_ready`: → IDLE, or re-enter DONE/CALC if a new request is accepted the same cycle.
  - Input ports are ignored in CALC.
- `result` and `zero` hold stable while `out_valid && !out_ready`.

## Timing
- Reset values: state IDLE, `out_valid`=0, `result`=0, `zero`=0, `busy`=0. `in_ready`=1 during and after reset.
- Single-cycle ops and special cases: `out_valid` rises on the edge after acceptance (latency 1).
- Multi-cycle ops: `busy`=1 for exactly XLEN cycles; `out_valid` rises XLEN+1 cycles after the acceptance edge.
- A result retired and a new request accepted on the same edge: the next result follows with the latency of the new op. No bubble for single-cycle ops.
- `rst_n` asserted mid-CALC or mid-DONE: the operation is aborted immediately. The result is never presented and `out_valid` drops asynchronously.
- `out_ready` held low: the unit stalls in DONE indefinitely and `in_ready` stays 0.

## Configuration
- `ALU_MULDIV_EN` defined:
  - The M-extension decode, the iterative engine, the CALC state, and the special cases are compiled in.
- `ALU_MULDIV_EN` undefined:
  - `funct7b0` is ignored, so such instructions execute as the base op selected by `funct3`/`funct7b5`.
  - All ops have latency 1.
  - `busy` is tied to 0.
  - No multiplier/divider logic is generated.

## Test plan
- XLEN=32, `alu_op`=10, R-type, `funct3`=000, `funct7b5`=1, a=5, b=7 → `result`=0xFFFFFFFE, `zero`=0, one cycle after accept. Back-to-back ADD 3+4 on the next cycle → 7 with no bubble.
- Shift and compare ops:
  - SRA: a=0x80000000, b=0x24 → 0xF8000000 (shift amount 4).
  - SLTU: a=1, b=0xFFFFFFFF → 1.
  - SLT with the same operands → 0.
- With `ALU_MULDIV_EN`:
  - MULH: a=0xFFFFFFFF (−1), b=2 → 0xFFFFFFFF. `busy` is high for 32 cycles and `out_valid` rises at cycle 33.
  - MULHU with the same operands → 1.
- Divide special cases:
  - DIV: a=−7, b=2 → 0xFFFFFFFD.
  - REM with the same operands → 0xFFFFFFFF.
  - DIV by zero → 0xFFFFFFFF with latency 1.
  - DIV 0x80000000 / −1 → 0x80000000.
  - REM of that pair → 0.
- Backpressure: hold `out_ready`=0 for 10 cycles after a result → `result` stable, `in_ready`=0. Then pulse `out_ready` → exactly one retirement.
- Assert `rst_n` low during cycle 10 of a DIVU → `out_valid` never asserts. After release: state IDLE and `in_ready`=1, and a fresh ADD completes correctly.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Execute stage that merges ALU control decode with the datapath.
//   It decodes alu_op/funct3/funct7 into the RV32I integer operations and,
//   when the ALU_MULDIV_EN macro is defined, the RV32M multiply/divide
//   operations. Those run on an iterative radix-2 engine, one bit per cycle.
//   Single-cycle ops present a registered result one cycle after acceptance.
//
//   Build option:
//     ALU_MULDIV_EN : compile in the M-extension decode, the iterative engine,
//                     the CALC state and the divide special cases. When it is
//                     undefined, funct7b0 is ignored and every op takes 1 cycle.
//
//   Ports:
//     clk, rst_n         clock (rising edge), async active-low reset
//     in_valid/in_ready  request handshake
//     alu_op             00 ADD, 01 SUB, 10 funct decode, 11 pass B
//     funct3, funct7b5   operation select / SUB-SRA select
//     funct7b0, is_rtype M-extension select, register-register flag
//     a, b               operands (XLEN)
//     out_valid/out_ready result handshake
//     result, zero       registered result and (result == 0)
//     busy               iterative engine active
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            funct7b0,
  input  logic            is_rtype,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef ALU_MULDIV_EN
  localparam logic [1:0] S_CALC = 2'd1;
`endif

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_result;
  logic            r_zero;

  logic            w_accept;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_now_res;
  logic            w_start_calc;
  logic [SHW-1:0]  w_shamt;

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign w_shamt   = b[SHW-1:0];

  // Base RV32I datapath
  always_comb begin
    w_base = '0;
    case (alu_op)
      2'b00: w_base = a + b;
      2'b01: w_base = a - b;
      2'b11: w_base = b;
      default: begin
        case (funct3)
          3'b000: w_base = (is_rtype && funct7b5) ? (a - b) : (a + b);
          3'b001: w_base = a << w_shamt;
          3'b010: w_base = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
          3'b011: w_base = {{(XLEN-1){1'b0}}, (a < b)};
          3'b100: w_base = a ^ b;
          // SRAI shares funct7b5 with SRA, so is_rtype is not consulted here
          3'b101: w_base = funct7b5 ? XLEN'($signed(a) >>> w_shamt) : (a >> w_shamt);
          3'b110: w_base = a | b;
          default: w_base = a & b;
        endcase
      end
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam logic [SHW:0]    CNT_INIT = (SHW+1)'(XLEN);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  // Engine state: r_prod is {hi, lo}. Multiply keeps {partial sum, multiplier};
  // divide keeps {partial remainder, dividend shifting into quotient}.
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_mcand;
  logic [SHW:0]      r_cnt;
  logic              r_is_div;
  logic              r_neg;
  logic              r_sel;

  logic            w_is_m, w_is_div, w_is_rem;
  logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic            w_div_zero, w_div_ovf, w_special;
  logic [XLEN-1:0] w_special_res;

  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_next;
  logic [2*XLEN-1:0] w_mul_fix;
  logic [XLEN-1:0]   w_div_raw;
  logic [XLEN-1:0]   w_calc_res;

  assign w_is_m   = (alu_op == 2'b10) && is_rtype && funct7b0;
  assign w_is_div = funct3[2];
  assign w_is_rem = funct3[1];

  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    if (w_is_div) begin
      w_a_signed = ~funct3[0];
      w_b_signed = ~funct3[0];
    end else begin
      w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010);
      w_b_signed = (funct3 == 3'b001);
    end
  end

  assign w_a_neg = w_a_signed && a[XLEN-1];
  assign w_b_neg = w_b_signed && b[XLEN-1];
  assign w_a_mag = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag = w_b_neg ? (~b + 1'b1) : b;

  assign w_div_zero = w_is_div && (b == '0);
  assign w_div_ovf  = w_is_div && !funct3[0] && (a == SMIN) && (b == '1);
  assign w_special  = w_div_zero || w_div_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) w_special_res = w_is_rem ? a : '1;
    else            w_special_res = w_is_rem ? '0 : a;
  end

  assign w_start_calc = w_is_m && !w_special;
  assign w_now_res    = w_is_m ? w_special_res : w_base;

  // One shift-add multiply step
  assign w_sum      = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_next = {w_sum, r_prod[XLEN-1:1]};

  // One restoring-divide step: trial subtract of the divisor from {rem, next dividend bit}
  assign w_diff     = r_prod[2*XLEN-1:XLEN-1] - {1'b0, r_mcand};
  assign w_div_next = {(w_diff[XLEN] ? r_prod[2*XLEN-2:XLEN-1] : w_diff[XLEN-1:0]),
                       r_prod[XLEN-2:0], ~w_diff[XLEN]};

  assign w_next = r_is_div ? w_div_next : w_mul_next;

  // Sign fix-up folded into the final iteration so DONE follows CALC directly
  assign w_mul_fix  = r_neg ? (~w_next + 1'b1) : w_next;
  assign w_div_raw  = r_sel ? w_next[2*XLEN-1:XLEN] : w_next[XLEN-1:0];
  assign w_calc_res = r_is_div ? (r_neg ? (~w_div_raw + 1'b1) : w_div_raw)
                               : (r_sel ? w_mul_fix[2*XLEN-1:XLEN] : w_mul_fix[XLEN-1:0]);

  assign busy = (r_state == S_CALC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod   <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg    <= 1'b0;
      r_sel    <= 1'b0;
    end else if (r_state == S_CALC) begin
      r_prod <= w_next;
      r_cnt  <= r_cnt - 1'b1;
    end else if (w_accept && w_start_calc) begin
      r_prod   <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
      r_mcand  <= w_is_div ? w_b_mag : w_a_mag;
      r_cnt    <= CNT_INIT;
      r_is_div <= w_is_div;
      r_neg    <= (w_is_div && w_is_rem) ? w_a_neg : (w_a_neg ^ w_b_neg);
      r_sel    <= w_is_div ? w_is_rem : (funct3 != 3'b000);
    end
  end
`else
  logic w_unused_f7b0;

  assign w_unused_f7b0 = funct7b0;
  assign w_start_calc  = 1'b0;
  assign w_now_res     = w_base;
  assign busy          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
`ifdef ALU_MULDIV_EN
        S_CALC: begin
          if (r_cnt == (SHW+1)'(1)) begin
            r_state  <= S_DONE;
            r_result <= w_calc_res;
            r_zero   <= (w_calc_res == '0);
          end
        end
`endif
        S_IDLE, S_DONE: begin
          if (w_accept) begin
`ifdef ALU_MULDIV_EN
            if (w_start_calc) begin
              r_state <= S_CALC;
            end else
`endif
            begin
              r_state  <= S_DONE;
              r_result <= w_now_res;
              r_zero   <= (w_now_res == '0);
            end
          end else if ((r_state == S_DONE) && out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        funct7b0;
  logic        is_rtype;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_retire = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .funct7b0  (funct7b0),
    .is_rtype  (is_rtype),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid && out_ready) n_retire++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic set_op(input logic [1:0] op, input logic [2:0] f3, input logic f7b5,
                        input logic f7b0, input logic rt, input logic [31:0] av,
                        input logic [31:0] bv);
    alu_op   = op;
    funct3   = f3;
    funct7b5 = f7b5;
    funct7b0 = f7b0;
    is_rtype = rt;
    a        = av;
    b        = bv;
  endtask

  // Issue one request, wait for its result, check value, latency and busy cycles.
  // Cycle 1 is the first negedge after the accepting edge.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic f7b5, input logic f7b0, input logic rt,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    int busy_cnt;
    @(negedge clk);
    set_op(op, f3, f7b5, f7b0, rt, av, bv);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy"}, 32'(busy_cnt), 32'(exp_lat - 1));
    chk(tag, result, exp);
    chk({tag, "_zero"}, 32'(zero), 32'(exp == 32'd0));
  endtask

  initial begin
    int r0;
    int ov_seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // SUB 5-7 followed back-to-back by ADD 3+4
    @(negedge clk);
    set_op(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_res", result, 32'hFFFF_FFFE);
    chk("sub_zero", 32'(zero), 32'd0);
    chk("b2b_rdy", 32'(in_ready), 32'd1);
    set_op(2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 32'd3, 32'd4);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_add", result, 32'd7);
    in_valid = 1'b0;

    // Base ops
    run_op("sra",    2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h24, 32'hF800_0000, 1);
    run_op("srai",   2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h4, 32'hF800_0000, 1);
    run_op("srl",    2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h24, 32'h0800_0000, 1);
    run_op("sll",    2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'h0000_0003, 32'h21, 32'h0000_0006, 1);
    run_op("sltu",   2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'd1, 1);
    run_op("slt",    2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("xor",    2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1);
    run_op("or",     2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 32'h00F0_0001, 32'h0F00_0010, 32'h0FF0_0011, 1);
    run_op("and",    2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 32'hF0F0_FFFF, 32'h0FF0_00F0, 32'h00F0_00F0, 1);
    run_op("addi",   2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 32'd5, 32'hFFFF_FFFB, 32'd0, 1);
    run_op("aluadd", 2'b00, 3'b111, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd1, 1);
    run_op("alusub", 2'b01, 3'b000, 1'b0, 1'b0, 1'b1, 32'd9, 32'd9, 32'd0, 1);
    run_op("lui",    2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000, 1);

`ifdef ALU_MULDIV_EN
    run_op("mul",    2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd6, 32'd7, 32'd42, 33);
    run_op("mulh",   2'b10, 3'b001, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("mulhu",  2'b10, 3'b011, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd1, 33);
    run_op("mulhsu", 2'b10, 3'b010, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("div",    2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem",    2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu",   2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu",   2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7, 32'd2, 33);
    run_op("div0",   2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'd123, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu0",  2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 32'd123, 32'd0, 32'd123, 1);
    run_op("divovf", 2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("removf", 2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
`else
    run_op("f7b0ign", 2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd6, 32'd7, 32'd13, 1);
    run_op("f7b0and", 2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 32'd6, 32'd7, 32'd6, 1);
`endif

    // Backpressure: result held, in_ready low, one retirement on a single pulse
    @(negedge clk);
    set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd10, 32'd20);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_result", result, 32'd30);
      chk("bp_rdy", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    r0        = n_retire;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_retire", 32'(n_retire - r0), 32'd1);
    chk("bp_after_valid", 32'(out_valid), 32'd0);

    // Reset during operation aborts it
    @(negedge clk);
`ifdef ALU_MULDIV_EN
    set_op(2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd1000, 32'd3);
`else
    set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1000, 32'd3);
`endif
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
`ifdef ALU_MULDIV_EN
    for (int i = 1; i < 10; i++) @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd1);
`else
    chk("abort_done", 32'(out_valid), 32'd1);
`endif
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_rdy", 32'(in_ready), 32'd1);
    chk("abort_busy0", 32'(busy), 32'd0);
    chk("abort_result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    ov_seen   = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    chk("abort_no_valid", 32'(ov_seen), 32'd0);
    chk("abort_idle_rdy", 32'(in_ready), 32'd1);
    run_op("post_rst_add", 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd40, 32'd2, 32'd42, 1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
